memory_stage: RTL and testbench

Memory stage of the five-stage Y86-64 pipeline, directly downstream of the execute stage. Latches the execute-stage outputs into the M pipeline register, performs data-memory reads and writes for rmmovq/mrmovq/call/ret/pushq/popq, and produces the memory-stage status and loaded value. Its outputs feed the W pipeline register, the forwarding logic, and pipeline control.

---
 rtl/y86_pkg.sv | 67 ++++++
 rtl/data_memory.sv | 52 +++++
 rtl/memory_stage.sv | 96 +++++++++
 tb/tb_memory_stage.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: one-hot status codes, instruction codes, register IDs
// and the M pipeline register layout used by the memory stage.
package y86_pkg;

  localparam logic [3:0] STAT_AOK = 4'b0001;
  localparam logic [3:0] STAT_HLT = 4'b0010;
  localparam logic [3:0] STAT_ADR = 4'b0100;
  localparam logic [3:0] STAT_INS = 4'b1000;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } m_reg_t;

  localparam m_reg_t M_BUBBLE = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    cnd:   1'b0,
    val_e: 64'd0,
    val_a: 64'd0,
    dst_e: RNONE,
    dst_m: RNONE
  };

  function automatic logic is_mem_read(input logic [3:0] icode);
    case (icode)
      I_MRMOVQ, I_RET, I_POPQ: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic is_mem_write(input logic [3:0] icode);
    case (icode)
      I_RMMOVQ, I_CALL, I_PUSHQ: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  // ret and popq address memory through the old stack pointer carried in valA
  function automatic logic addr_from_val_a(input logic [3:0] icode);
    case (icode)
      I_RET, I_POPQ: return 1'b1;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory.sv
// Byte-addressed little-endian data memory: combinational 8-byte read,
// synchronous 8-byte write, and a 65-bit range check on the access address.
module data_memory
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic [63:0] i_addr,
  input  logic        i_access,
  input  logic        i_read,
  input  logic        i_we,
  input  logic [63:0] i_wdata,
  output logic [63:0] o_rdata,
  output logic        o_error
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0]    r_mem [MEM_BYTES] = '{default: 8'h00};
  logic [64:0]   w_last_s;
  logic [AW-1:0] w_base_s;

  // Range check on the last byte touched; the extra bit turns 64-bit wrap into an error
  always_comb begin
    w_last_s = {1'b0, i_addr} + 65'd7;
    w_base_s = i_addr[AW-1:0];
    o_error  = i_access & (w_last_s >= 65'(MEM_BYTES));
  end

  // Little-endian 8-byte read, forced to zero when idle or out of range
  always_comb begin
    o_rdata = 64'd0;
    if (i_read && !o_error) begin
      for (int k = 0; k < 8; k++) begin
        o_rdata[8*k +: 8] = r_mem[w_base_s + AW'(k)];
      end
    end else begin
      o_rdata = 64'd0;
    end
  end

  // Little-endian 8-byte write committed at the edge ending the M cycle
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int k = 0; k < 8; k++) begin
        r_mem[w_base_s + AW'(k)] <= i_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 pipeline memory stage: M pipeline register, data memory access,
// loaded value and memory-stage status for the W register and pipeline control.
module memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        M_bubble,
  input  logic [3:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  output logic [3:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] m_valM,
  output logic [3:0]  m_stat,
  output logic        dmem_error
);

  m_reg_t      r_m;
  logic        w_read;
  logic        w_write;
  logic        w_access;
  logic        w_we;
  logic        w_err;
  logic [63:0] w_addr;

  // M pipeline register; a bubble outranks the execute-stage values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m <= M_BUBBLE;
    end else if (M_bubble) begin
      r_m <= M_BUBBLE;
    end else begin
      r_m <= '{stat: e_stat, icode: e_icode, cnd: e_cnd, val_e: e_valE,
               val_a: e_valA, dst_e: e_dstE, dst_m: e_dstM};
    end
  end

  // Access decode; only healthy in-range writes reach memory, never during reset
  always_comb begin
    w_read   = is_mem_read(r_m.icode);
    w_write  = is_mem_write(r_m.icode);
    w_access = w_read | w_write;
    w_addr   = r_m.val_e;
    if (addr_from_val_a(r_m.icode)) begin
      w_addr = r_m.val_a;
    end else begin
      w_addr = r_m.val_e;
    end
    w_we = w_write & (r_m.stat == STAT_AOK) & ~w_err & rst_n;
  end

  // Memory-stage status: an address fault overrides the incoming status
  always_comb begin
    m_stat = r_m.stat;
    if (w_err) begin
      m_stat = STAT_ADR;
    end else begin
      m_stat = r_m.stat;
    end
  end

  data_memory #(
    .MEM_BYTES (MEM_BYTES)
  ) u_dmem (
    .clk      (clk),
    .i_addr   (w_addr),
    .i_access (w_access),
    .i_read   (w_read),
    .i_we     (w_we),
    .i_wdata  (r_m.val_a),
    .o_rdata  (m_valM),
    .o_error  (w_err)
  );

  assign dmem_error = w_err;
  assign M_stat     = r_m.stat;
  assign M_icode    = r_m.icode;
  assign M_cnd      = r_m.cnd;
  assign M_valE     = r_m.val_e;
  assign M_valA     = r_m.val_a;
  assign M_dstE     = r_m.dst_e;
  assign M_dstM     = r_m.dst_m;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage: reset, store/load, push/pop,
// range errors, bubble/status handling and reset in the middle of a store.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        M_bubble;
  logic [3:0]  e_stat, e_icode, e_dstE, e_dstM;
  logic        e_cnd;
  logic [63:0] e_valE, e_valA;
  logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
  logic        M_cnd;
  logic [63:0] M_valE, M_valA, m_valM;
  logic [3:0]  m_stat;
  logic        dmem_error;

  int n_checks = 0;
  int n_errors = 0;

  memory_stage #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n), .M_bubble(M_bubble),
    .e_stat(e_stat), .e_icode(e_icode), .e_cnd(e_cnd),
    .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .m_valM(m_valM), .m_stat(m_stat), .dmem_error(dmem_error)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] st, input logic [3:0] ic,
                       input logic [63:0] ve, input logic [63:0] va);
    e_stat  = st;
    e_icode = ic;
    e_cnd   = 1'b0;
    e_valE  = ve;
    e_valA  = va;
    e_dstE  = 4'h4;
    e_dstM  = 4'h5;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    M_bubble = 1'b0;
    e_stat   = 4'($urandom);
    e_icode  = 4'($urandom);
    e_cnd    = 1'($urandom);
    e_valE   = {32'($urandom), 32'($urandom)};
    e_valA   = {32'($urandom), 32'($urandom)};
    e_dstE   = 4'($urandom);
    e_dstM   = 4'($urandom);
    step();
    step();
    n_checks++; if (M_icode !== 4'h1) begin n_errors++; $display("FAIL reset_icode got %h exp 1", M_icode); end
    n_checks++; if (M_stat !== 4'b0001) begin n_errors++; $display("FAIL reset_stat got %b exp 0001", M_stat); end
    n_checks++; if (M_dstE !== 4'hF || M_dstM !== 4'hF) begin n_errors++; $display("FAIL reset_dst got %h/%h exp f/f", M_dstE, M_dstM); end
    n_checks++; if (M_valE !== 64'd0 || M_valA !== 64'd0 || M_cnd !== 1'b0) begin n_errors++; $display("FAIL reset_vals got %h/%h/%b exp 0", M_valE, M_valA, M_cnd); end
    n_checks++; if (m_valM !== 64'd0) begin n_errors++; $display("FAIL reset_valM got %h exp 0", m_valM); end
    rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    drive(4'b0001, 4'h4, 64'h100, 64'h1122334455667788);
    step();
    n_checks++; if (M_icode !== 4'h4 || M_valE !== 64'h100) begin n_errors++; $display("FAIL store_capture got %h/%h exp 4/100", M_icode, M_valE); end
    n_checks++; if (m_valM !== 64'd0 || dmem_error !== 1'b0) begin n_errors++; $display("FAIL store_valM got %h/%b exp 0/0", m_valM, dmem_error); end
    drive(4'b0001, 4'h5, 64'h100, 64'h0);
    step();
    n_checks++; if (m_valM !== 64'h1122334455667788) begin n_errors++; $display("FAIL b2b_load got %h exp 1122334455667788", m_valM); end
    n_checks++; if (M_dstM !== 4'h5 || m_stat !== 4'b0001) begin n_errors++; $display("FAIL load_dst_stat got %h/%b exp 5/0001", M_dstM, m_stat); end
    drive(4'b0001, 4'h5, 64'hFF, 64'h0);
    step();
    n_checks++; if (m_valM !== 64'h2233445566778800) begin n_errors++; $display("FAIL le_bytes got %h exp 2233445566778800", m_valM); end
  endtask

  task automatic test_push_pop();
    drive(4'b0001, 4'hA, 64'h3F8, 64'hABCD);
    step();
    n_checks++; if (dmem_error !== 1'b0 || m_stat !== 4'b0001) begin n_errors++; $display("FAIL push_edge got %b/%b exp 0/0001", dmem_error, m_stat); end
    drive(4'b0001, 4'hB, 64'h400, 64'h3F8);
    step();
    n_checks++; if (m_valM !== 64'hABCD) begin n_errors++; $display("FAIL pop_valM got %h exp abcd", m_valM); end
  endtask

  task automatic test_out_of_range();
    drive(4'b0001, 4'h4, 64'h3F9, 64'hFFFFFFFFFFFFFFFF);
    step();
    n_checks++; if (dmem_error !== 1'b1 || m_stat !== 4'b0100) begin n_errors++; $display("FAIL oor_store got %b/%b exp 1/0100", dmem_error, m_stat); end
    drive(4'b0001, 4'h5, 64'h3F8, 64'h0);
    step();
    n_checks++; if (m_valM !== 64'hABCD || dmem_error !== 1'b0) begin n_errors++; $display("FAIL oor_unchanged got %h/%b exp abcd/0", m_valM, dmem_error); end
    drive(4'b0001, 4'h4, 64'hFFFFFFFFFFFFFFFC, 64'h1);
    step();
    n_checks++; if (dmem_error !== 1'b1 || m_stat !== 4'b0100) begin n_errors++; $display("FAIL wrap got %b/%b exp 1/0100", dmem_error, m_stat); end
    drive(4'b0001, 4'h5, 64'h3F9, 64'h0);
    step();
    n_checks++; if (dmem_error !== 1'b1 || m_valM !== 64'd0) begin n_errors++; $display("FAIL oor_load got %b/%h exp 1/0", dmem_error, m_valM); end
    drive(4'b0001, 4'h6, 64'hFFFFFFFFFFFFFFFF, 64'h0);
    step();
    n_checks++; if (dmem_error !== 1'b0 || m_stat !== 4'b0001) begin n_errors++; $display("FAIL no_access got %b/%b exp 0/0001", dmem_error, m_stat); end
  endtask

  task automatic test_bubble_status();
    M_bubble = 1'b1;
    drive(4'b0001, 4'h4, 64'h100, 64'hDEAD);
    step();
    n_checks++; if (M_icode !== 4'h1 || M_dstE !== 4'hF || M_valA !== 64'd0) begin n_errors++; $display("FAIL bubble got %h/%h/%h exp 1/f/0", M_icode, M_dstE, M_valA); end
    M_bubble = 1'b0;
    drive(4'b1000, 4'h4, 64'h100, 64'hBEEF);
    step();
    n_checks++; if (m_stat !== 4'b1000 || dmem_error !== 1'b0) begin n_errors++; $display("FAIL ins_pass got %b/%b exp 1000/0", m_stat, dmem_error); end
    drive(4'b0001, 4'h5, 64'h100, 64'h0);
    step();
    n_checks++; if (m_valM !== 64'h1122334455667788) begin n_errors++; $display("FAIL no_write got %h exp 1122334455667788", m_valM); end
    drive(4'b0010, 4'h4, 64'h3F9, 64'h0);
    step();
    n_checks++; if (m_stat !== 4'b0100) begin n_errors++; $display("FAIL adr_over_hlt got %b exp 0100", m_stat); end
  endtask

  task automatic test_reset_midop();
    drive(4'b0001, 4'h4, 64'h200, 64'h5555);
    step();
    n_checks++; if (M_icode !== 4'h4) begin n_errors++; $display("FAIL midop_load got %h exp 4", M_icode); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (M_icode !== 4'h1 || M_valE !== 64'd0) begin n_errors++; $display("FAIL async_clear got %h/%h exp 1/0", M_icode, M_valE); end
    step();
    rst_n = 1'b1;
    drive(4'b0001, 4'h5, 64'h200, 64'h0);
    step();
    n_checks++; if (M_icode !== 4'h5 || m_valM !== 64'd0) begin n_errors++; $display("FAIL midop_mem got %h/%h exp 5/0", M_icode, m_valM); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_push_pop();
    test_out_of_range();
    test_bubble_status();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
